// File: rtl/ped_request_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : ped_request_conditioner
// Purpose  : Pedestrian button front-end. Synchronises and debounces the raw
//            NS/EW crosswalk buttons, turns each accepted press into a latched
//            request level held until the matching red light is seen, and
//            keeps a saturating count of accepted requests per direction.
// Revision : 1.0 - initial release
// ============================================================================
module ped_request_conditioner #(
    parameter int CLK_FREQ    = 50000000,
    parameter int DEBOUNCE_MS = 20,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_NS_raw,
    input  logic             btn_EW_raw,
    input  logic             NS_red,
    input  logic             EW_red,
    output logic             btn_NS_clean,
    output logic             btn_EW_clean,
    output logic             press_NS,
    output logic             press_EW,
    output logic             ped_NS,
    output logic             ped_EW,
    output logic [CNT_W-1:0] req_cnt_NS,
    output logic [CNT_W-1:0] req_cnt_EW
);

    localparam int DEBOUNCE_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_MS;
    localparam int DB_W            = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DB_W-1:0]  c_db_zero = '0;
    localparam logic [DB_W-1:0]  c_db_one  = DB_W'(1);
    localparam logic [DB_W-1:0]  c_db_last = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RISE    = 2'd1;
    localparam logic [1:0] S_PRESSED = 2'd2;
    localparam logic [1:0] S_FALL    = 2'd3;

    // Bit order: [0] NS button, [1] EW button, [2] NS red, [3] EW red
    logic [3:0] w_async_in;
    logic [3:0] r_sync_meta;
    logic [3:0] r_sync;

    logic [1:0]       w_clean_bus;
    logic [1:0]       w_press_bus;
    logic [1:0]       w_ped_bus;
    logic [CNT_W-1:0] w_req_cnt_bus [2];

    assign w_async_in = {EW_red, NS_red, btn_EW_raw, btn_NS_raw};

    // Two-flop synchroniser for every asynchronous input; only r_sync is used
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_meta <= 4'b0000;
            r_sync      <= 4'b0000;
        end else begin
            r_sync_meta <= w_async_in;
            r_sync      <= r_sync_meta;
        end
    end

    // Channel 0 is NS, channel 1 is EW; both are identical and independent
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic             w_btn_s;
        logic             w_red_s;
        logic [1:0]       r_state;
        logic [1:0]       w_state_nxt;
        logic [DB_W-1:0]  r_cnt;
        logic [DB_W-1:0]  w_cnt_nxt;
        logic             r_clean;
        logic             r_press;
        logic             w_clean_nxt;
        logic             w_press_nxt;
        logic             r_ped;
        logic [CNT_W-1:0] r_req_cnt;

        assign w_btn_s = r_sync[ch];
        assign w_red_s = r_sync[ch+2];

        // Debounce state, stable-time counter and the registered clean/press outputs
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= S_IDLE;
                r_cnt   <= c_db_zero;
                r_clean <= 1'b0;
                r_press <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_clean <= w_clean_nxt;
                r_press <= w_press_nxt;
            end
        end

        // Next-state logic: a level change must persist DEBOUNCE_CYCLES synced cycles
        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            case (r_state)
                S_IDLE: begin
                    if (w_btn_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = S_PRESSED;
                            w_cnt_nxt   = c_db_zero;
                        end else begin
                            w_state_nxt = S_RISE;
                            w_cnt_nxt   = c_db_one;
                        end
                    end
                end
                S_RISE: begin
                    if (!w_btn_s) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = c_db_zero;
                    end else if (r_cnt == c_db_last) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = c_db_zero;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_db_one;
                    end
                end
                S_PRESSED: begin
                    if (!w_btn_s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = c_db_zero;
                        end else begin
                            w_state_nxt = S_FALL;
                            w_cnt_nxt   = c_db_one;
                        end
                    end
                end
                S_FALL: begin
                    if (w_btn_s) begin
                        w_state_nxt = S_PRESSED;
                        w_cnt_nxt   = c_db_zero;
                    end else if (r_cnt == c_db_last) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = c_db_zero;
                    end else begin
                        w_cnt_nxt   = r_cnt + c_db_one;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = c_db_zero;
                end
            endcase
        end

        // Output decode from the next state so clean and press register on the same edge
        always_comb begin
            w_clean_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_FALL);
            w_press_nxt = w_clean_nxt && !r_clean;
        end

        // Request latch: a served (red) direction clears and blocks acceptance that edge
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_ped     <= 1'b0;
                r_req_cnt <= '0;
            end else if (w_red_s) begin
                r_ped     <= 1'b0;
            end else if (r_press && !r_ped) begin
                r_ped     <= 1'b1;
                if (r_req_cnt != c_cnt_max) begin
                    r_req_cnt <= r_req_cnt + c_cnt_one;
                end
            end
        end

        assign w_clean_bus[ch]   = r_clean;
        assign w_press_bus[ch]   = r_press;
        assign w_ped_bus[ch]     = r_ped;
        assign w_req_cnt_bus[ch] = r_req_cnt;
    end

    assign btn_NS_clean = w_clean_bus[0];
    assign btn_EW_clean = w_clean_bus[1];
    assign press_NS     = w_press_bus[0];
    assign press_EW     = w_press_bus[1];
    assign ped_NS       = w_ped_bus[0];
    assign ped_EW       = w_ped_bus[1];
    assign req_cnt_NS   = w_req_cnt_bus[0];
    assign req_cnt_EW   = w_req_cnt_bus[1];

endmodule
`default_nettype wire
